// File: rtl/axi4_burst_scheduler_pkg.sv
// Shared types, constants and helpers for the AXI4 burst scheduler.
package axi4_burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } burst_sched_state_t;

  localparam int AXI_4K_BYTES = 4096;

  // True when a burst starting at the given 4 KB offset runs past the page end.
  // 14 bits hold 4095 + 256*bytes_per_beat for engines up to 256 bits wide.
  function automatic logic crosses_4k(input logic [11:0] addr,
                                      input logic [7:0]  len,
                                      input logic [13:0] bytes_per_beat);
    logic [13:0] span;
    logic [13:0] end_off;
    span    = ({6'd0, len} + 14'd1) * bytes_per_beat;
    end_off = {2'b00, addr} + span;
    return end_off > 14'(AXI_4K_BYTES);
  endfunction

endpackage

// File: rtl/axi4_burst_scheduler_if.sv
// Requester command/response bus plus engine command bus of the scheduler.
interface axi4_burst_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*8-1:0]      req_len;
  logic [NUM_REQ-1:0]        resp_valid;
  logic                      resp_error;

  logic                      eng_start;
  logic                      eng_write;
  logic [ADDR_W-1:0]         eng_addr;
  logic [7:0]                eng_len;
  logic                      eng_done;
  logic                      eng_error;

  // Scheduler side: takes requester commands, drives the engine.
  modport master (
    input  req_valid, req_write, req_addr, req_len, eng_done, eng_error,
    output req_ready, resp_valid, resp_error, eng_start, eng_write, eng_addr, eng_len
  );

  // Environment side: requesters and the burst engine.
  modport slave (
    output req_valid, req_write, req_addr, req_len, eng_done, eng_error,
    input  req_ready, resp_valid, resp_error, eng_start, eng_write, eng_addr, eng_len
  );

endinterface

// File: rtl/axi4_burst_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_grant+1 with wrap.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  // First requester found after the previous owner wins.
  always_comb begin : pick
    logic found;
    int   cand;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int off = 1; off <= N; off++) begin
      cand = int'(last_grant) + off;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/axi4_burst_scheduler.sv
// Round-robin scheduler sharing one AXI4 burst engine between NUM_REQ requesters.
//
// state | meaning
// IDLE  | waiting for a request; req_ready to the round-robin winner
// ISSUE | eng_start pulse visible; watchdog cleared
// WAIT  | engine busy; waiting for eng_done or watchdog expiry
// RESP  | resp_valid/resp_error pulse to the owner; owner becomes last_grant
module axi4_burst_scheduler
  import axi4_burst_pkg::*;
#(
  parameter int NUM_REQ              = 4,
  parameter int C_M00_AXI_ADDR_WIDTH = 32,
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES       = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  axi4_burst_scheduler_if.master     bus,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int GID_W          = $clog2(NUM_REQ);
  localparam int AW             = C_M00_AXI_ADDR_WIDTH;
  localparam int BYTES_PER_BEAT = C_M00_AXI_DATA_WIDTH / 8;
  localparam int CNT_W          = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit WDOG_EN        = (TIMEOUT_CYCLES != 0);
  // Timeout fires on the WAIT cycle whose increment would reach TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  burst_sched_state_t state;
  logic [GID_W-1:0]   last_grant;
  logic [CNT_W-1:0]   cnt;

  logic [NUM_REQ-1:0] win_onehot;
  logic [GID_W-1:0]   win_idx;
  logic [AW-1:0]      sel_addr;
  logic [7:0]         sel_len;
  logic               sel_write;
  logic               sel_cross;
  logic [NUM_REQ-1:0] own_onehot;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(GID_W)) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .grant      (win_onehot),
    .grant_idx  (win_idx)
  );

  // Payload of the current winner and its 4 KB legality.
  always_comb begin
    sel_addr   = bus.req_addr[int'(win_idx)*AW +: AW];
    sel_len    = bus.req_len[int'(win_idx)*8 +: 8];
    sel_write  = bus.req_write[win_idx];
    sel_cross  = crosses_4k(sel_addr[11:0], sel_len, 14'(BYTES_PER_BEAT));
    own_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
  end

  // Accept strobe is the only combinational output; silenced during reset.
  assign bus.req_ready = (state == IDLE && !reset) ? win_onehot : '0;

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      last_grant     <= GID_W'(NUM_REQ - 1);
      grant_id       <= '0;
      cnt            <= '0;
      busy           <= 1'b0;
      bus.eng_start  <= 1'b0;
      bus.eng_write  <= 1'b0;
      bus.eng_addr   <= '0;
      bus.eng_len    <= '0;
      bus.resp_valid <= '0;
      bus.resp_error <= 1'b0;
    end else begin
      bus.eng_start  <= 1'b0;
      bus.resp_valid <= '0;
      bus.resp_error <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            grant_id      <= win_idx;
            bus.eng_write <= sel_write;
            bus.eng_addr  <= sel_addr;
            bus.eng_len   <= sel_len;
            busy          <= 1'b1;
            if (sel_cross) begin
              bus.resp_valid <= win_onehot;
              bus.resp_error <= 1'b1;
              state          <= RESP;
            end else begin
              bus.eng_start <= 1'b1;
              state         <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (bus.eng_done) begin
            bus.resp_valid <= own_onehot;
            bus.resp_error <= bus.eng_error;
            state          <= RESP;
          end else if (WDOG_EN && cnt == CNT_LIMIT) begin
            bus.resp_valid <= own_onehot;
            bus.resp_error <= 1'b1;
            state          <= RESP;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          last_grant <= grant_id;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
